sbox_config_ctrl: RTL and testbench
===================================

# sbox_config_ctrl

Configuration controller for an array of `NUM_ELEM` unidirectional switch-box elements, each consuming an 8-bit select word `c` (four 2-bit mux selects: N=`c[1:0]`, E=`c[3:2]`, S=`c[5:4]`, W=`c[7:6]`; select `2'b11` drives that output to 0). A host writes per-element words into a shadow bank over a valid/ready command port, then commits them atomically to the active bank that drives the fabric. The controller also supports clearing the shadow bank to the isolate pattern and reading back active words. It sits between the configuration bus and the switch-box tile.

## Interface
- `NUM_ELEM`, 4: number of switch-box elements controlled (≥2).
- `ADDR_W`, 2: element address width; requires `2**ADDR_W >= NUM_ELEM`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cfg_valid`  in  1  command present.
- `cfg_ready`  out  1  controller can accept a command.
- `cfg_op`  in  2  00 WRITE, 01 COMMIT, 10 CLEAR, 11 READ.
- `cfg_addr`  in  `ADDR_W`  element index for WRITE/READ.
- `cfg_data`  in  8  select word for WRITE.
- `c_out`  out  `8*NUM_ELEM`  active bank; element i occupies bits `[8i+7:8i]`.
- `rd_valid`  out  1  one-cycle pulse, READ result valid.
- `rd_data`  out  8  READ result.
- `err`  out  1  sticky: out-of-range address seen.

## Operation
- The isolate word is `8'hFF`: all selects are 11, so all outputs are 0.
- Reset sets shadow and active entries to `8'hFF`, `c_out` to all ones, `cfg_ready`=1, `rd_valid`=0, `rd_data`=`8'hFF`, `err`=0, state IDLE, and the clear counter to 0.
- A command is accepted on a rising edge with `cfg_valid && cfg_ready`. `cfg_ready` is 1 only in IDLE.
- States:
  - IDLE
  - COMMIT: 1 cycle
  - CLEAR: `NUM_ELEM` cycles
- WRITE:
  - `shadow[cfg_addr] <= cfg_data` at the accept edge; state stays IDLE.
  - If `cfg_addr >= NUM_ELEM`, nothing is written and `err` is set.
- COMMIT:
  - IDLE→COMMIT on accept.
  - In COMMIT, all `active[i] <= shadow[i]` in one edge, then COMMIT→IDLE.
  - `c_out` never shows a mix of old and new words.
- CLEAR:
  - IDLE→CLEAR on accept, with counter=0.
  - Each CLEAR cycle writes `shadow[counter] <= 8'hFF` and increments the counter.
  - After the write to index `NUM_ELEM-1`, the state returns to IDLE and the counter goes to 0.
  - The active bank is untouched.
  - `err` is cleared at the CLEAR accept edge.
- READ:
  - At the accept edge, `rd_data <= active[cfg_addr]` and `rd_valid <= 1`. State stays IDLE.
  - If out of range, `rd_data <= 8'hFF`, `rd_valid <= 1`, and `err` is set.
- `rd_valid` drops to 0 on the next edge unless another READ is accepted.
- `cfg_addr` and `cfg_data` are ignored for COMMIT and CLEAR.

## Timing
- Commands accepted back-to-back: WRITE and READ, one per cycle at full throughput.
- COMMIT accepted at edge k: `cfg_ready`=0 in cycle k..k+1, `c_out` updates at edge k+1, `cfg_ready`=1 after edge k+1.
- CLEAR accepted at edge k: shadow entries are written at edges k+1..k+`NUM_ELEM`, and `cfg_ready`=1 after edge k+`NUM_ELEM`.
- READ latency: data is registered at the accept edge and visible for exactly one cycle.
- WRITE followed by READ of the same address returns the active value, not the shadow value.
- A READ accepted in the same cycle as COMMIT cannot occur, because only one command is accepted per cycle.
- `c_out` is driven directly from registers, with no combinational path from `cfg_*`.
- `rst_n` low during COMMIT or CLEAR aborts immediately to the reset state. A partial clear is discarded because the whole shadow bank resets to `8'hFF`.
- Reset deassertion is synchronous to `clk`, handled by an external synchronizer.

## Structure
- A shared Verilog header `sbox_cfg_defs.vh` holds:
  - op encodings `OP_WRITE`, `OP_COMMIT`, `OP_CLEAR`, `OP_READ`
  - `SBOX_ISOLATE = 8'hFF`
  - state encodings
- One natural sub-module, `sbox_cfg_bank`: a parameterized `NUM_ELEM×8` register array with per-entry write-enable, a bulk-load input, and a reset value of `SBOX_ISOLATE`.
  - Instantiated twice: once as shadow, once as active.
- The FSM, the clear counter (width `ADDR_W`) and the READ/err logic live in `sbox_config_ctrl`.

## Test plan
- Reset, then sample → `c_out`=`32'hFFFF_FFFF` (NUM_ELEM=4), `cfg_ready`=1, `err`=0, `rd_valid`=0.
- WRITE addr0=`8'h24`, addr3=`8'h39`, with no COMMIT → `c_out` unchanged. Then COMMIT → `c_out`=`32'h39FF_FF24` exactly one edge after acceptance, and `cfg_ready` low for one cycle.
- After the commit above: CLEAR → `cfg_ready` low for 4 cycles and `c_out` unchanged. Then COMMIT → `c_out`=`32'hFFFF_FFFF`.
- Back-to-back READ addr3, READ addr0 → `rd_valid` high for 2 consecutive cycles, `rd_data`=`8'h39` then `8'h24`.
- With NUM_ELEM=3, WRITE addr3=`8'h00` → shadow unchanged, `err`=1. READ addr3 → `rd_data`=`8'hFF`. CLEAR → `err`=0.
- COMMIT accepted, then `rst_n` pulsed low mid-COMMIT → `c_out`=all ones, state IDLE, and `cfg_ready`=1 immediately after reset release.

Source files
------------

// File: rtl/sbox_config_ctrl_pkg.sv
// Shared encodings for the switch-box configuration controller:
// command opcodes, the isolate select word and FSM state encodings.
package sbox_config_ctrl_pkg;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  // All four selects at 2'b11 drive every switch-box output to 0.
  localparam logic [7:0] SBOX_ISOLATE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_COMMIT = 2'b01,
    ST_CLEAR  = 2'b10
  } state_e;

endpackage

// File: rtl/sbox_cfg_bank.sv
// NUM_ELEM x 8-bit configuration register bank with per-entry write enables
// and a bulk load; every entry resets to the isolate word.
module sbox_cfg_bank
  import sbox_config_ctrl_pkg::*;
#(
  parameter int NUM_ELEM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_ELEM-1:0]   wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  load_en,
  input  logic [8*NUM_ELEM-1:0] load_data,
  output logic [8*NUM_ELEM-1:0] q
);

  logic [8*NUM_ELEM-1:0] mem_d;
  logic [8*NUM_ELEM-1:0] mem_q;

  // Bulk load takes priority over single-entry writes.
  always_comb begin
    mem_d = mem_q;
    if (load_en) begin
      mem_d = load_data;
    end else begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        mem_d[8*i +: 8] = wr_en[i] ? wr_data : mem_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= {NUM_ELEM{SBOX_ISOLATE}};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign q = mem_q;

endmodule

// File: rtl/sbox_config_ctrl.sv
// Switch-box configuration controller: shadow/active banks with atomic
// commit, multi-cycle shadow clear, active-bank readback and sticky error.
module sbox_config_ctrl
  import sbox_config_ctrl_pkg::*;
#(
  parameter int NUM_ELEM = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_op,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [7:0]            cfg_data,
  output logic [8*NUM_ELEM-1:0] c_out,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  output logic                  err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ELEM - 1);

  state_e              state_d, state_q;
  logic [ADDR_W-1:0]   cnt_d, cnt_q;
  logic                ready_d, ready_q;
  logic                rd_valid_d, rd_valid_q;
  logic [7:0]          rd_data_d, rd_data_q;
  logic                err_d, err_q;

  logic                  accept_s;
  logic                  addr_ok_s;
  logic [7:0]            rd_word_s;
  logic [NUM_ELEM-1:0]   sh_wr_en_s;
  logic [7:0]            sh_wr_data_s;
  logic [8*NUM_ELEM-1:0] shadow_s;
  logic [8*NUM_ELEM-1:0] active_s;

  assign accept_s = cfg_valid && ready_q;

  // When the address space is fully populated every address is valid.
  if (NUM_ELEM >= (1 << ADDR_W)) begin : g_addr_full
    assign addr_ok_s = 1'b1;
  end else begin : g_addr_part
    localparam logic [ADDR_W-1:0] NUM_ELEM_A = ADDR_W'(NUM_ELEM);
    assign addr_ok_s = (cfg_addr < NUM_ELEM_A);
  end

  // Readback mux over the active bank; isolate word when out of range.
  always_comb begin
    rd_word_s = SBOX_ISOLATE;
    for (int i = 0; i < NUM_ELEM; i++) begin
      rd_word_s = (cfg_addr == ADDR_W'(i)) ? active_s[8*i +: 8] : rd_word_s;
    end
  end

  // Shadow writes come either from the clear sweep or an accepted WRITE.
  always_comb begin
    sh_wr_data_s = (state_q == ST_CLEAR) ? SBOX_ISOLATE : cfg_data;
    for (int i = 0; i < NUM_ELEM; i++) begin
      sh_wr_en_s[i] = ((state_q == ST_CLEAR) && (cnt_q == ADDR_W'(i))) ||
                      (accept_s && (cfg_op == OP_WRITE) && addr_ok_s &&
                       (cfg_addr == ADDR_W'(i)));
    end
  end

  // Next-state, clear counter, readback and error logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (cfg_op)
            OP_WRITE: begin
              err_d = addr_ok_s ? err_q : 1'b1;
            end
            OP_COMMIT: begin
              state_d = ST_COMMIT;
            end
            OP_CLEAR: begin
              state_d = ST_CLEAR;
              cnt_d   = '0;
              err_d   = 1'b0;
            end
            OP_READ: begin
              rd_valid_d = 1'b1;
              if (addr_ok_s) begin
                rd_data_d = rd_word_s;
              end else begin
                rd_data_d = SBOX_ISOLATE;
                err_d     = 1'b1;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= SBOX_ISOLATE;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  sbox_cfg_bank #(.NUM_ELEM(NUM_ELEM)) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (sh_wr_en_s),
    .wr_data   (sh_wr_data_s),
    .load_en   (1'b0),
    .load_data ({NUM_ELEM{SBOX_ISOLATE}}),
    .q         (shadow_s)
  );

  // The active bank only ever changes by a whole-bank load from the shadow.
  sbox_cfg_bank #(.NUM_ELEM(NUM_ELEM)) u_active (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     ({NUM_ELEM{1'b0}}),
    .wr_data   (SBOX_ISOLATE),
    .load_en   (state_q == ST_COMMIT),
    .load_data (shadow_s),
    .q         (active_s)
  );

  assign cfg_ready = ready_q;
  assign c_out     = active_s;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sbox_config_ctrl.sv
// Scoreboard bench for sbox_config_ctrl: a 4-element and a 3-element instance
// share one command driver; READ results are checked by per-instance monitors.
module tb_sbox_config_ctrl;

  localparam logic [1:0] W = 2'b00, C = 2'b01, CL = 2'b10, R = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, sel_b;
  logic [1:0]  cmd_op, cmd_addr;
  logic [7:0]  cmd_data;

  logic        valid_a, ready_a, rd_valid_a, err_a;
  logic [31:0] c_out_a;
  logic [7:0]  rd_data_a;
  logic        valid_b, ready_b, rd_valid_b, err_b;
  logic [23:0] c_out_b;
  logic [7:0]  rd_data_b;
  logic        cur_ready;

  int checks = 0;
  int failures = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] exp_a, exp_b;
  int n;

  always #5 clk = ~clk;

  assign valid_a   = cmd_valid & ~sel_b;
  assign valid_b   = cmd_valid & sel_b;
  assign cur_ready = sel_b ? ready_b : ready_a;

  sbox_config_ctrl #(.NUM_ELEM(4), .ADDR_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_valid(valid_a), .cfg_ready(ready_a),
    .cfg_op(cmd_op), .cfg_addr(cmd_addr), .cfg_data(cmd_data),
    .c_out(c_out_a), .rd_valid(rd_valid_a), .rd_data(rd_data_a), .err(err_a)
  );

  sbox_config_ctrl #(.NUM_ELEM(3), .ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_valid(valid_b), .cfg_ready(ready_b),
    .cfg_op(cmd_op), .cfg_addr(cmd_addr), .cfg_data(cmd_data),
    .c_out(c_out_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b), .err(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] addr,
                      input logic [7:0] data, input logic [7:0] exp_rd);
    int k = 0;
    while (!cur_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!cur_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
    end
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    if (op == R) begin
      if (sel_b) q_b.push_back(exp_rd);
      else q_a.push_back(exp_rd);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!cur_ready && cyc < 50) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  // Read-result monitors: every rd_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && rd_valid_a) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_a_unexpected: got rd_valid=1 data=%h expected no read", rd_data_a);
      end else begin
        exp_a = q_a.pop_front();
        chk("rd_a", {24'h0, rd_data_a}, {24'h0, exp_a});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rd_valid_b) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_b_unexpected: got rd_valid=1 data=%h expected no read", rd_data_b);
      end else begin
        exp_b = q_b.pop_front();
        chk("rd_b", {24'h0, rd_data_b}, {24'h0, exp_b});
      end
    end
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; sel_b = 1'b0;
    cmd_op = 2'b00; cmd_addr = 2'b00; cmd_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_c_out_a", c_out_a, 32'hFFFF_FFFF);
    chk("rst_c_out_b", {8'h0, c_out_b}, 32'h00FF_FFFF);
    chk("rst_ready", {31'h0, ready_a}, 32'h1);
    chk("rst_err", {31'h0, err_a}, 32'h0);
    chk("rst_rd_valid", {31'h0, rd_valid_a}, 32'h0);
    chk("rst_rd_data", {24'h0, rd_data_a}, 32'h0000_00FF);

    send(W, 2'd0, 8'h24, 8'h00);
    send(W, 2'd3, 8'h39, 8'h00);
    chk("write_no_commit", c_out_a, 32'hFFFF_FFFF);
    send(C, 2'd0, 8'h00, 8'h00);
    chk("commit_ready_low", {31'h0, ready_a}, 32'h0);
    chk("commit_not_yet", c_out_a, 32'hFFFF_FFFF);
    wait_ready(n);
    chk("commit_cycles", n, 32'd1);
    chk("commit_c_out", c_out_a, 32'h39FF_FF24);

    send(R, 2'd3, 8'h00, 8'h39);
    send(R, 2'd0, 8'h00, 8'h24);
    chk("b2b_rd_valid", {31'h0, rd_valid_a}, 32'h1);
    @(posedge clk); #1;
    chk("rd_valid_drop", {31'h0, rd_valid_a}, 32'h0);

    send(CL, 2'd0, 8'h00, 8'h00);
    wait_ready(n);
    chk("clear_cycles", n, 32'd4);
    chk("clear_active_kept", c_out_a, 32'h39FF_FF24);
    send(R, 2'd3, 8'h00, 8'h39);
    send(C, 2'd0, 8'h00, 8'h00);
    wait_ready(n);
    chk("commit_after_clear", c_out_a, 32'hFFFF_FFFF);

    send(W, 2'd1, 8'h5A, 8'h00);
    send(R, 2'd1, 8'h00, 8'hFF);
    send(C, 2'd0, 8'h00, 8'h00);
    wait_ready(n);
    chk("commit_addr1", c_out_a, 32'hFFFF_5AFF);
    send(R, 2'd1, 8'h00, 8'h5A);
    chk("err_a_clean", {31'h0, err_a}, 32'h0);

    send(W, 2'd2, 8'h77, 8'h00);
    send(C, 2'd0, 8'h00, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("abort_c_out", c_out_a, 32'hFFFF_FFFF);
    chk("abort_ready", {31'h0, ready_a}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_ready", {31'h0, ready_a}, 32'h1);
    @(posedge clk); #1;
    chk("post_rst_c_out", c_out_a, 32'hFFFF_FFFF);
    send(C, 2'd0, 8'h00, 8'h00);
    wait_ready(n);
    chk("post_rst_commit", c_out_a, 32'hFFFF_FFFF);

    sel_b = 1'b1;
    send(W, 2'd0, 8'h12, 8'h00);
    chk("b_err_clean", {31'h0, err_b}, 32'h0);
    send(W, 2'd3, 8'h00, 8'h00);
    chk("b_err_write_oor", {31'h0, err_b}, 32'h1);
    send(C, 2'd0, 8'h00, 8'h00);
    wait_ready(n);
    chk("b_commit_c_out", {8'h0, c_out_b}, 32'h00FF_FF12);
    send(R, 2'd3, 8'h00, 8'hFF);
    send(R, 2'd0, 8'h00, 8'h12);
    chk("b_err_sticky", {31'h0, err_b}, 32'h1);
    send(CL, 2'd0, 8'h00, 8'h00);
    chk("b_err_cleared", {31'h0, err_b}, 32'h0);
    wait_ready(n);
    chk("b_clear_cycles", n, 32'd3);
    send(C, 2'd0, 8'h00, 8'h00);
    wait_ready(n);
    chk("b_commit_cleared", {8'h0, c_out_b}, 32'h00FF_FFFF);
    send(R, 2'd3, 8'h00, 8'hFF);
    chk("b_err_read_oor", {31'h0, err_b}, 32'h1);

    repeat (3) @(posedge clk);
    #1;
    chk("q_a_drained", q_a.size(), 32'd0);
    chk("q_b_drained", q_b.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
